// File: rtl/ball_locator_if.sv
// Pixel-in / ball-result bundle between the detection stage and the locator.
// The detection stage (or a bench) drives the _i signals, the locator drives the _o signals.
interface ball_locator_if #(
    parameter int CNT_W = 20
);
    logic             enable_i;
    logic             pix_valid_i;
    logic [7:0]       r_i;
    logic [7:0]       g_i;
    logic [7:0]       b_i;
    logic [12:0]      h_cnt_i;
    logic [12:0]      v_cnt_i;
    logic [12:0]      ball_x_o;
    logic [12:0]      ball_y_o;
    logic             ball_found_o;
    logic [CNT_W-1:0] pixel_count_o;
    logic             ball_valid_o;
    logic             frame_err_o;

    modport master (
        output enable_i, pix_valid_i, r_i, g_i, b_i, h_cnt_i, v_cnt_i,
        input  ball_x_o, ball_y_o, ball_found_o, pixel_count_o, ball_valid_o, frame_err_o
    );

    modport slave (
        input  enable_i, pix_valid_i, r_i, g_i, b_i, h_cnt_i, v_cnt_i,
        output ball_x_o, ball_y_o, ball_found_o, pixel_count_o, ball_valid_o, frame_err_o
    );
endinterface

// File: rtl/ball_locator.sv
// Ball locator: accumulates a bounding box and a count of marker-coloured
// pixels over each active frame and publishes the box centre at end of frame.
module ball_locator #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MARK_R     = 255,
    parameter int MARK_G     = 0,
    parameter int MARK_B     = 0,
    parameter int MIN_PIXELS = 16,
    parameter int CNT_W      = 20
) (
    input  logic          clk,
    input  logic          rst,
    ball_locator_if.slave bus
);
    localparam logic [12:0]      H_LIM   = 13'(H_ACTIVE);
    localparam logic [12:0]      V_LIM   = 13'(V_ACTIVE);
    localparam logic [12:0]      H_LAST  = 13'(H_ACTIVE - 1);
    localparam logic [12:0]      V_LAST  = 13'(V_ACTIVE - 1);
    localparam logic [7:0]       MR      = 8'(MARK_R);
    localparam logic [7:0]       MG      = 8'(MARK_G);
    localparam logic [7:0]       MB      = 8'(MARK_B);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCUM    = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Pixel classification
    logic accept, marked, sof, eof;
    // FSM control towards the datapath
    logic clr, fold, do_update;

    // Per-axis accumulators: index 0 is column (H), index 1 is row (V)
    logic [12:0] coord [2];
    logic [12:0] min_q [2];
    logic [12:0] min_d [2];
    logic [12:0] max_q [2];
    logic [12:0] max_d [2];
    logic [CNT_W-1:0] count_q, count_d;

    // Published results
    logic [12:0]      ball_x_q, ball_x_d;
    logic [12:0]      ball_y_q, ball_y_d;
    logic             found_q, found_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    assign coord[0] = bus.h_cnt_i;
    assign coord[1] = bus.v_cnt_i;

    // Decode whether the current pixel counts, is marker-coloured, or frames the image
    always_comb begin
        accept = bus.pix_valid_i && bus.enable_i && (bus.h_cnt_i < H_LIM) && (bus.v_cnt_i < V_LIM);
        marked = (bus.r_i == MR) && (bus.g_i == MG) && (bus.b_i == MB);
        sof    = accept && (bus.h_cnt_i == 13'd0) && (bus.v_cnt_i == 13'd0);
        eof    = accept && (bus.h_cnt_i == H_LAST) && (bus.v_cnt_i == V_LAST);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and datapath control; disable always abandons the frame silently
    always_comb begin
        state_d   = state_q;
        clr       = 1'b0;
        fold      = 1'b0;
        do_update = 1'b0;
        err_d     = 1'b0;
        if (!bus.enable_i) begin
            state_d = WAIT_SOF;
        end else begin
            case (state_q)
                WAIT_SOF: begin
                    if (sof) begin
                        clr     = 1'b1;
                        fold    = marked;
                        state_d = eof ? UPDATE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (sof) begin
                        // A new frame started before the old one ended: restart,
                        // unless this pixel also closes the frame (1x1 image).
                        clr  = 1'b1;
                        fold = marked;
                        if (eof) begin
                            state_d = UPDATE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (accept) begin
                        fold = marked;
                        if (eof) begin
                            state_d = UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    do_update = 1'b1;
                    state_d   = WAIT_SOF;
                end
                default: begin
                    state_d = WAIT_SOF;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic [12:0] min_base, max_base;

            // Bounding-box extent for one axis: restart on clear, widen on marked pixels
            always_comb begin
                min_base  = clr ? 13'h1FFF : min_q[gi];
                max_base  = clr ? 13'h0000 : max_q[gi];
                min_d[gi] = (fold && (coord[gi] < min_base)) ? coord[gi] : min_base;
                max_d[gi] = (fold && (coord[gi] > max_base)) ? coord[gi] : max_base;
            end

            // Bounding-box registers for one axis
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    min_q[gi] <= 13'h1FFF;
                    max_q[gi] <= 13'h0000;
                end else begin
                    min_q[gi] <= min_d[gi];
                    max_q[gi] <= max_d[gi];
                end
            end
        end
    endgenerate

    // Marked-pixel counter, saturating so a huge blob never wraps to a small count
    always_comb begin
        logic [CNT_W-1:0] cnt_base;
        cnt_base = clr ? '0 : count_q;
        count_d  = (fold && (cnt_base != CNT_MAX)) ? cnt_base + 1'b1 : cnt_base;
    end

    // Result computation: centre only moves when the frame actually held a ball
    always_comb begin
        logic [13:0] sum_x, sum_y;
        sum_x     = {1'b0, min_q[0]} + {1'b0, max_q[0]};
        sum_y     = {1'b0, min_q[1]} + {1'b0, max_q[1]};
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        found_d   = found_q;
        pix_cnt_d = pix_cnt_q;
        valid_d   = do_update;
        if (do_update) begin
            pix_cnt_d = count_q;
            found_d   = (count_q >= MIN_CNT);
            if (count_q >= MIN_CNT) begin
                ball_x_d = sum_x[13:1];
                ball_y_d = sum_y[13:1];
            end
        end
    end

    // Count and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            ball_x_q  <= '0;
            ball_y_q  <= '0;
            found_q   <= 1'b0;
            pix_cnt_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            found_q   <= found_d;
            pix_cnt_q <= pix_cnt_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign bus.ball_x_o      = ball_x_q;
    assign bus.ball_y_o      = ball_y_q;
    assign bus.ball_found_o  = found_q;
    assign bus.pixel_count_o = pix_cnt_q;
    assign bus.ball_valid_o  = valid_q;
    assign bus.frame_err_o   = err_q;
endmodule

// File: doc/ball_locator.md
Name: ball_locator

Overview:
- Consumes the recoloured pixel stream from the ball-detection stage, where detected ball pixels are painted in the marker colour (default pure red).
- Accumulates a per-frame bounding box and marked-pixel count over the active area.
- At end of frame, publishes the ball centre (box midpoint) with a found flag and a one-cycle valid strobe.
- Output feeds the paddle/game control logic; it is not part of the video path.

Parameters:
- H_ACTIVE, 640, active pixels per line; H counts 0..H_ACTIVE-1.
- V_ACTIVE, 480, active lines per frame; V counts 0..V_ACTIVE-1.
- MARK_R, 255, marker red value.
- MARK_G, 0, marker green value.
- MARK_B, 0, marker blue value.
- MIN_PIXELS, 16, minimum marked pixels for BALL_FOUND.
- CNT_W, 20, width of the pixel counter.

Ports:
- CLK  in  1  pixel clock.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  block enable.
- PIX_VALID  in  1  R/G/B_IN and counters carry a valid pixel this cycle.
- R_IN  in  8  pixel red from the detection stage.
- G_IN  in  8  pixel green.
- B_IN  in  8  pixel blue.
- VGA_H_CNT  in  13  pixel column of the current pixel.
- VGA_V_CNT  in  13  pixel row of the current pixel.
- BALL_X  out  13  centre column of the last found ball.
- BALL_Y  out  13  centre row of the last found ball.
- BALL_FOUND  out  1  last completed frame had at least MIN_PIXELS marked pixels.
- PIXEL_COUNT  out  CNT_W  marked-pixel count of the last completed frame.
- BALL_VALID  out  1  one-cycle strobe: outputs were updated for a completed frame.
- FRAME_ERR  out  1  one-cycle strobe: a frame was truncated and its data discarded.

Behaviour:
- Reset (async, RST=1): state=WAIT_SOF; all outputs 0; accumulators cleared (min_x/min_y = all ones, max_x/max_y = 0, count = 0).
- Accepted pixel:
  - Condition: PIX_VALID=1, ENABLE=1, H<H_ACTIVE and V<V_ACTIVE. Other pixels are ignored entirely.
  - Marked: R_IN==MARK_R && G_IN==MARK_G && B_IN==MARK_B (exact match).
  - SOF pixel: accepted with H==0, V==0.
  - EOF pixel: accepted with H==H_ACTIVE-1, V==V_ACTIVE-1.
- State WAIT_SOF:
  - Ignores everything except an SOF pixel.
  - On SOF: clear accumulators, fold in the SOF pixel if marked, go to ACCUM.
- State ACCUM:
  - Each marked accepted pixel: min/max update on H and V; count +1, saturating at 2^CNT_W-1.
  - On EOF: fold in the EOF pixel, then go to UPDATE.
  - On SOF (frame truncated before EOF): pulse FRAME_ERR for one cycle, re-clear accumulators, fold in the SOF pixel, stay in ACCUM. Outputs are not updated.
- State UPDATE (exactly one cycle), then return to WAIT_SOF:
  - PIXEL_COUNT <= count.
  - BALL_FOUND <= (count >= MIN_PIXELS).
  - If found: BALL_X <= (min_x+max_x)>>1 and BALL_Y <= (min_y+max_y)>>1, with 14-bit sums and no overflow. If not found, BALL_X/BALL_Y hold their previous values.
  - BALL_VALID=1 for this single cycle, every completed frame whether or not a ball was found.
- Latency: EOF pixel sampled at edge N; outputs and BALL_VALID change at edge N+1; BALL_VALID drops at edge N+2.
- ENABLE=0:
  - In any state, go to WAIT_SOF at the next edge; the partial frame is discarded with no FRAME_ERR.
  - Outputs hold; strobes are 0.
  - Re-enable mid-frame: nothing is accumulated until the next SOF.
- A pixel that is both SOF and EOF (H_ACTIVE=V_ACTIVE=1) is treated as SOF then EOF in the same cycle → UPDATE.
- Async reset mid-frame: immediate return to the reset state; strobes deassert at once.

Test Plan:
- Bench setting for all scenarios: H_ACTIVE=8, V_ACTIVE=6, MIN_PIXELS=4.
- Single ball: full frame with marked pixels at H=2..4, V=1..3 (9 px) → one cycle after EOF, BALL_VALID=1, BALL_X=3, BALL_Y=2, PIXEL_COUNT=9, BALL_FOUND=1.
- Noise rejection: frame 1 as above; frame 2 has 3 marked px at (7,5),(6,5),(7,4) → frame 2 gives BALL_FOUND=0, PIXEL_COUNT=3, BALL_X/BALL_Y stay 3/2, BALL_VALID pulses.
- Truncated frame: SOF, marks at rows 0-2, then a new SOF at V=3 → FRAME_ERR pulses once, no BALL_VALID; the following complete frame reports only its own pixels.
- Mid-frame start: release reset at V=2 with marks on rows 2-5 → no BALL_VALID at that frame's end; the next full frame reports correctly.
- Non-marker and gated pixels: (255,0,1), (254,0,0), off-active counters (H=8) and PIX_VALID=0 pixels ignored → PIXEL_COUNT=0, BALL_FOUND=0; ENABLE dropped mid-frame → no strobes, outputs held.
- Corner extremes: marks only at (0,0) and (7,5), MIN_PIXELS=2 → BALL_X=3, BALL_Y=2, PIXEL_COUNT=2, BALL_VALID exactly one cycle.
